pipe_stage_buffer: RTL and testbench

Parametrised elastic pipeline stage register that replaces the fixed single-entry latches between processor pipeline stages (fetch/decode, decode/execute, execute/memory, memory/writeback). It stores up to DEPTH packed stage payloads in a small ring buffer with a valid/ready handshake on both sides, a registered upstream ready, and a synchronous flush. It decouples stall propagation: a downstream stall no longer combinationally back-pressures the whole front end. The stage payload is opaque: the caller packs control and datapath fields into WIDTH bits.

---
 rtl/pipe_stage_buffer_pkg.sv | 16 +
 rtl/pipe_stage_buffer_if.sv | 22 ++
 rtl/pipe_stage_buffer_ring_ptr.sv | 24 ++
 rtl/pipe_stage_buffer.sv | 80 ++++++++
 tb/tb_pipe_stage_buffer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types and helpers for the elastic pipeline stage buffer.
package pipe_stage_buffer_pkg;

    // Occupancy update selected by {push, pop}.
    typedef enum logic [1:0] {
        OCC_HOLD = 2'b00,
        OCC_POP  = 2'b01,
        OCC_PUSH = 2'b10,
        OCC_BOTH = 2'b11
    } occ_op_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Valid/ready handshake on both sides of a pipeline stage buffer.
interface pipe_stage_buffer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // master: the surrounding pipeline; slave: the buffer itself.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_buffer_ring_ptr.sv
// Modulo-DEPTH pointer with synchronous clear; used for both ring buffer pointers.
module ring_ptr
    import pipe_stage_buffer_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage register: DEPTH-entry ring buffer, registered in_ready, synchronous flush.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                flush,
    pipe_stage_buffer_if.slave  bus,
    output logic [CW-1:0]       count
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    count_next;
    logic             in_ready_q;
    logic             out_valid;
    logic             push;
    logic             pop;

    assign out_valid = (count != '0);
    assign push      = bus.in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & bus.out_ready & ~flush;

    ring_ptr #(.DEPTH(DEPTH)) u_wp (
        .CLK (CLK),
        .RST (RST),
        .clr (flush),
        .inc (push),
        .ptr (wp)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_rp (
        .CLK (CLK),
        .RST (RST),
        .clr (flush),
        .inc (pop),
        .ptr (rp)
    );

    // NOTE: default assigned first so no path leaves count_next unassigned (no latch).
    always_comb begin
        count_next = count;
        unique case (occ_op_e'({push, pop}))
            OCC_PUSH: count_next = count + 1'b1;
            OCC_POP:  count_next = count - 1'b1;
            default:  count_next = count;
        endcase
    end

    // in_ready looks at count_next, never at out_ready, so a full buffer
    // only reopens in the cycle after the pop.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            count      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next < CW'(DEPTH));
        end
    end

    // NOTE: the array has no reset; count gates every visible read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wp] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem[rp] : '0;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer at DEPTH = 2 and DEPTH = 3.
module tb_pipe_stage_buffer;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush2;
    logic       flush3;
    logic [1:0] count2;
    logic [1:0] count3;

    pipe_stage_buffer_if #(.WIDTH(W)) bus2 ();
    pipe_stage_buffer_if #(.WIDTH(W)) bus3 ();

    pipe_stage_buffer #(.WIDTH(W), .DEPTH(2)) u_dut2 (
        .CLK   (clk),
        .RST   (rst),
        .flush (flush2),
        .bus   (bus2.slave),
        .count (count2)
    );

    pipe_stage_buffer #(.WIDTH(W), .DEPTH(3)) u_dut3 (
        .CLK   (clk),
        .RST   (rst),
        .flush (flush3),
        .bus   (bus3.slave),
        .count (count3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the DEPTH = 3 instance.
    logic [W-1:0] q3[$];
    logic         rdy3 = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of dut3 inputs and advance the reference model past the coming edge.
    task automatic drive3(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        logic psh;
        logic pp;
        bus3.in_valid  = iv;
        bus3.in_data   = id;
        bus3.out_ready = ordy;
        flush3         = fl;
        psh = iv & rdy3 & ~fl;
        pp  = ordy & (q3.size() != 0) & ~fl;
        if (fl) begin
            q3.delete();
            rdy3 = 1'b1;
        end else begin
            if (pp) void'(q3.pop_front());
            if (psh) q3.push_back(id);
            rdy3 = (q3.size() < 3);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        flush2         = 1'b0;
        flush3         = 1'b0;
        bus2.in_valid  = 1'b1;
        bus2.in_data   = 32'hDEAD_BEEF;
        bus2.out_ready = 1'b0;
        bus3.in_valid  = 1'b1;
        bus3.in_data   = 32'hDEAD_BEEF;
        bus3.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                rst           = 1'b0;
                bus2.in_valid = 1'b0;
                bus3.in_valid = 1'b0;
            end
            tick();
            n_checks++;
            if ({bus2.out_valid, bus2.out_data, count2, bus2.in_ready} !== {1'b0, 32'h0, 2'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_d2 cyc%0d: got v=%b d=%h c=%0d r=%b, want v=0 d=0 c=0 r=1",
                         i, bus2.out_valid, bus2.out_data, count2, bus2.in_ready);
            end
            n_checks++;
            if ({bus3.out_valid, bus3.out_data, count3, bus3.in_ready} !== {1'b0, 32'h0, 2'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_d3 cyc%0d: got v=%b d=%h c=%0d r=%b, want v=0 d=0 c=0 r=1",
                         i, bus3.out_valid, bus3.out_data, count3, bus3.in_ready);
            end
        end
        q3.delete();
        rdy3 = 1'b1;
    endtask

    task automatic test_streaming();
        logic [W-1:0] q2[$];
        logic         rdy2 = 1'b1;
        logic [W-1:0] exp_d;
        logic         psh;
        logic         pp;
        for (int i = 0; i < 11; i++) begin
            exp_d = (q2.size() != 0) ? q2[0] : '0;
            n_checks++;
            if (bus2.out_valid !== (q2.size() != 0) || bus2.out_data !== exp_d ||
                count2 !== 2'(q2.size()) || bus2.in_ready !== rdy2) begin
                n_fail++;
                $display("FAIL stream cyc%0d: got v=%b d=%h c=%0d r=%b, want v=%b d=%h c=%0d r=%b",
                         i, bus2.out_valid, bus2.out_data, count2, bus2.in_ready,
                         q2.size() != 0, exp_d, q2.size(), rdy2);
            end
            if (i >= 1 && i <= 8) begin
                n_checks++;
                if (bus2.out_data !== 32'(i) || count2 !== 2'd1 || bus2.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_fixed cyc%0d: got d=%h c=%0d r=%b, want d=%h c=1 r=1",
                             i, bus2.out_data, count2, bus2.in_ready, i);
                end
            end
            bus2.in_valid  = (i < 8);
            bus2.in_data   = 32'(i + 1);
            bus2.out_ready = 1'b1;
            psh = bus2.in_valid & rdy2;
            pp  = q2.size() != 0;
            if (pp) void'(q2.pop_front());
            if (psh) q2.push_back(bus2.in_data);
            rdy2 = (q2.size() < 2);
            tick();
        end
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
    endtask

    task automatic test_fill();
        logic         st_iv[11]   = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [W-1:0] st_d[11]    = '{'hA, 'hB, 'hC, 'hD, 'hD, 'hD, 'hD, 0, 0, 0, 0};
        logic         st_rdy[11]  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0};
        logic [W-1:0] drained[$];
        logic [W-1:0] want[4]     = '{'hA, 'hB, 'hC, 'hD};
        logic [W-1:0] exp_d;
        for (int i = 0; i < 11; i++) begin
            exp_d = (q3.size() != 0) ? q3[0] : '0;
            n_checks++;
            if (bus3.out_valid !== (q3.size() != 0) || bus3.out_data !== exp_d ||
                count3 !== 2'(q3.size()) || bus3.in_ready !== rdy3) begin
                n_fail++;
                $display("FAIL fill step%0d: got v=%b d=%h c=%0d r=%b, want v=%b d=%h c=%0d r=%b",
                         i, bus3.out_valid, bus3.out_data, count3, bus3.in_ready,
                         q3.size() != 0, exp_d, q3.size(), rdy3);
            end
            if (i == 4 || i == 6) begin
                n_checks++;
                if (count3 !== ((i == 4) ? 2'd3 : 2'd2) || bus3.in_ready !== (i == 6)) begin
                    n_fail++;
                    $display("FAIL fill_backpressure step%0d: got c=%0d r=%b, want c=%0d r=%b",
                             i, count3, bus3.in_ready, (i == 4) ? 3 : 2, i == 6);
                end
            end
            if (st_rdy[i] && bus3.out_valid) drained.push_back(bus3.out_data);
            drive3(st_iv[i], st_d[i], st_rdy[i], 1'b0);
            tick();
        end
        n_checks++;
        if (drained.size() != 4 || drained[0] !== want[0] || drained[1] !== want[1] ||
            drained[2] !== want[2] || drained[3] !== want[3]) begin
            n_fail++;
            $display("FAIL fill_order: got %0d items %p, want A B C D", drained.size(), drained);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] exp_d;
        drive3(1'b1, 32'h11, 1'b0, 1'b0);
        tick();
        drive3(1'b1, 32'h22, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (count3 !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_setup: got c=%0d, want c=2", count3);
        end
        drive3(1'b1, 32'h55, 1'b1, 1'b1);
        tick();
        n_checks++;
        if ({bus3.out_valid, bus3.out_data, count3, bus3.in_ready} !== {1'b0, 32'h0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b d=%h c=%0d r=%b, want v=0 d=0 c=0 r=1",
                     bus3.out_valid, bus3.out_data, count3, bus3.in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            drive3(i == 2, 32'h66, 1'b1, 1'b0);
            tick();
            exp_d = (q3.size() != 0) ? q3[0] : '0;
            n_checks++;
            if (bus3.out_valid !== (q3.size() != 0) || bus3.out_data !== exp_d || count3 !== 2'(q3.size())) begin
                n_fail++;
                $display("FAIL flush_after cyc%0d: got v=%b d=%h c=%0d, want v=%b d=%h c=%0d",
                         i, bus3.out_valid, bus3.out_data, count3, q3.size() != 0, exp_d, q3.size());
            end
            n_checks++;
            if (bus3.out_data === 32'h55) begin
                n_fail++;
                $display("FAIL flush_leak cyc%0d: got d=%h, want anything but 55", i, bus3.out_data);
            end
        end
    endtask

    task automatic test_wrap();
        logic         pend = 1'b0;
        logic [W-1:0] pdata = '0;
        logic [W-1:0] seq = 32'h1000;
        logic [W-1:0] exp_d;
        logic         acc;
        for (int i = 0; i < 1000; i++) begin
            exp_d = (q3.size() != 0) ? q3[0] : '0;
            n_checks++;
            if (bus3.out_valid !== (q3.size() != 0) || bus3.out_data !== exp_d ||
                count3 !== 2'(q3.size()) || bus3.in_ready !== rdy3) begin
                n_fail++;
                $display("FAIL wrap cyc%0d: got v=%b d=%h c=%0d r=%b, want v=%b d=%h c=%0d r=%b",
                         i, bus3.out_valid, bus3.out_data, count3, bus3.in_ready,
                         q3.size() != 0, exp_d, q3.size(), rdy3);
            end
            n_checks++;
            if (u_dut3.wp > 2'd2 || u_dut3.rp > 2'd2) begin
                n_fail++;
                $display("FAIL wrap_ptr cyc%0d: got wp=%0d rp=%0d, want both <= 2", i, u_dut3.wp, u_dut3.rp);
            end
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend  = 1'b1;
                pdata = seq;
                seq++;
            end
            acc = pend & rdy3;
            drive3(pend, pend ? pdata : '0, $urandom_range(0, 2) != 0, 1'b0);
            if (acc) pend = 1'b0;
            tick();
        end
        drive3(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        drive3(1'b1, 32'h77, 1'b0, 1'b0);
        tick();
        drive3(1'b1, 32'h88, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        drive3(1'b1, 32'h99, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({bus3.out_valid, bus3.out_data, count3, bus3.in_ready} !== {1'b0, 32'h0, 2'd0, 1'b1} ||
                u_dut3.wp !== 2'd0 || u_dut3.rp !== 2'd0) begin
                n_fail++;
                $display("FAIL priority cyc%0d: got v=%b d=%h c=%0d r=%b wp=%0d rp=%0d, want v=0 d=0 c=0 r=1 wp=0 rp=0",
                         i, bus3.out_valid, bus3.out_data, count3, bus3.in_ready, u_dut3.wp, u_dut3.rp);
            end
            rst = 1'b0;
            drive3(1'b0, '0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill();
        test_flush();
        test_wrap();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
